fifo_rd_fwft: RTL and testbench

//  Read-side output stage that sits directly downstream of the FIFO pointer block and its RAM.

---
 rtl/fifo_rd_fwft_pkg.sv | 17 +
 rtl/fifo_rd_fwft.sv | 87 ++++++++
 tb/tb_fifo_rd_fwft.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_fwft_pkg.sv
// Shared types for the FIFO read-side FWFT output stage.
// Occupancy encoding of the 2-slot output buffer.
package fifo_rd_fwft_pkg;

  localparam int LVL_W = 2;

  typedef enum logic [LVL_W-1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } lvl_e;

  function automatic logic [LVL_W-1:0] lvl_bits(input lvl_e l);
    return LVL_W'(l);
  endfunction

endpackage

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through read stage: registered-read RAM plus
// pointer empty/advance turned into a valid/ready stream.
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rd_empty,
  output logic          o_rd_advance,
  input  logic [DW-1:0] i_ram_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready,
  output logic [1:0]    o_level
);

  lvl_e          cnt_q, cnt_d;
  logic [DW-1:0] slot0_q, slot0_d;
  logic [DW-1:0] slot1_q, slot1_d;
  logic          win;
  logic          wout;

  // Pop depends on registered state only, never on i_ready.
  assign o_rd_advance = ~rst & ~i_rd_empty
                      & (cnt_q != LVL_FULL);
  assign win     = o_rd_advance;
  assign o_valid = (cnt_q != LVL_EMPTY);
  assign wout    = o_valid & i_ready;
  assign o_data  = slot0_q;
  assign o_level = lvl_bits(cnt_q);

  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (cnt_q)
      LVL_EMPTY: begin
        if (win) begin
          slot0_d = i_ram_data;
          cnt_d   = LVL_ONE;
        end
      end
      LVL_ONE: begin
        if (win && !wout) begin
          slot1_d = i_ram_data;
          cnt_d   = LVL_FULL;
        end else if (win && wout) begin
          slot0_d = i_ram_data;
        end else if (wout) begin
          cnt_d   = LVL_EMPTY;
        end
      end
      LVL_FULL: begin
        if (wout) begin
          slot0_d = slot1_q;
          cnt_d   = LVL_ONE;
        end
      end
      default: begin
        cnt_d = LVL_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= LVL_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // A third word would be dropped silently; trap it.
  always @(posedge clk) begin
    if (!rst) begin
      assert (o_level != 2'd3);
      assert (!(win && cnt_q == LVL_FULL));
    end
  end

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Scoreboard bench for fifo_rd_fwft with a queue-based
// pointer-block/RAM model upstream.
module tb_fifo_rd_fwft;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd_empty;
  logic        o_rd_advance;
  logic [31:0] i_ram_data;
  logic        o_valid;
  logic [31:0] o_data;
  logic        i_ready = 1'b0;
  logic [1:0]  o_level;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic adv_s = 1'b0;

  logic [31:0] src[$];
  logic [31:0] exp_q[$];

  fifo_rd_fwft #(.DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd_empty   (i_rd_empty),
    .o_rd_advance (o_rd_advance),
    .i_ram_data   (i_ram_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_level      (o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic refresh();
    i_rd_empty = (src.size() == 0);
    i_ram_data = (src.size() == 0) ? 32'h0 : src[0];
  endtask

  task automatic push(input logic [31:0] w);
    src.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Pointer block + RAM model: pop on advance, head re-read after edge.
  always @(negedge clk) adv_s = o_rd_advance;

  always @(posedge clk) begin
    if (adv_s && !rst && src.size() != 0) begin
      void'(src.pop_front());
      pops++;
    end
    #1 refresh();
  end

  // Monitor: compares every accepted word and watches hold stability.
  logic        hold_p = 1'b0;
  logic [31:0] data_p = '0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("level_range", 32'(o_level <= 2'd2), 1);
      if (hold_p && o_valid)
        chk("hold_stable", o_data, data_p);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none",
                   o_data);
        end else begin
          chk("data_order", o_data, exp_q.pop_front());
        end
      end
      hold_p = o_valid && !i_ready;
      data_p = o_data;
    end else begin
      hold_p = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int nv;
    int n;
    refresh();
    // 1: reset with data waiting
    for (int i = 0; i < 8; i++) push(32'h10 + i);
    repeat (2) begin
      @(negedge clk);
      chk("rst_adv", o_rd_advance, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_level", o_level, 0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("first_pop", o_rd_advance, 1);
    chk("first_valid", o_valid, 0);
    // 2: streaming, one word per cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", o_valid, 1);
      chk("stream_level", o_level, 1);
    end
    @(negedge clk);
    chk("stream_end", o_valid, 0);
    // 3: backpressure
    tick();
    i_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 5; i++) push(32'h20 + i);
    repeat (6) @(negedge clk);
    chk("bp_pops", pops - p0, 2);
    chk("bp_level", o_level, 2);
    chk("bp_adv", o_rd_advance, 0);
    chk("bp_data", o_data, 32'h20);
    tick();
    i_ready = 1'b1;
    drain();
    // 4: toggling ready
    tick();
    for (int i = 0; i < 6; i++) push(32'h30 + i);
    for (int i = 0; i < 24; i++) begin
      tick();
      i_ready = ~i_ready;
    end
    i_ready = 1'b1;
    drain();
    // 5: empty source, then one word
    tick();
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_adv", o_rd_advance, 0);
      chk("idle_valid", o_valid, 0);
    end
    tick();
    push(32'hA5);
    nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    chk("single_cycles", nv, 1);
    chk("single_left", exp_q.size(), 0);
    // 6: reset while full
    tick();
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h40 + i);
    n = 0;
    while (o_level != 2'd2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_level", o_level, 2);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_level", o_level, 0);
    chk("arst_adv", o_rd_advance, 0);
    src.delete();
    exp_q.delete();
    refresh();
    tick();
    tick();
    rst = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h50 + i);
    drain();
    repeat (3) @(negedge clk);
    chk("final_valid", o_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
